// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, W cycles per operation, result latched on DONE entry.
// Optional signed overflow flag built only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow,
  output logic         ovf
);
  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   sa, sb;
  logic [W-2:0]   wr;
  logic [W-1:0]   wr_nx;
  logic [CW-1:0]  cnt;
  logic           br, br_nx, d, accept, last;

  assign accept = start & (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(W - 1));
  assign d      = sa[0] ^ sb[0] ^ br;
  assign br_nx  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
  // wr holds the W-1 bits produced so far; the newest bit completes the word
  assign wr_nx  = {d, wr};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      wr     <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      wr  <= '0;
      br  <= 1'b0;
      cnt <= '0;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      wr  <= wr_nx[W-1:1];
      br  <= br_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        diff   <= wr_nx;
        borrow <= br_nx;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;
  // On the last bit sa[0]/sb[0] are the operand sign bits and d is the result sign
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  ovf_q <= 1'b0;
    else if (!accept && last)    ovf_q <= (sa[0] != sb[0]) & (d != sa[0]);
  end
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (W=8): latency, results, start-during-RUN, reset abort, back-to-back.
module tb_serial_subtractor;
  localparam int W = 8;
`ifdef SERIAL_SUB_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow, ovf;
  logic [W-1:0] diff;

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives start for one edge and follows the whole operation.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    int n = 0;
    int nb = 0;
    logic moved = 1'b0;
    logic [W-1:0] held;
    held  = diff;
    start = 1'b1; a = av; b = bv;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) start = 1'b0;
      if (!done) begin
        nb += busy;
        if (diff !== held) moved = 1'b1;
      end
    end while (!done && n < 40);
    chk({tag, " latency"}, n, W + 1);
    chk({tag, " busy_cycles"}, nb, W);
    chk({tag, " diff_hold"}, moved, 0);
    chk({tag, " diff"}, diff, ed);
    chk({tag, " borrow"}, borrow, eb);
    chk({tag, " ovf"}, ovf, eo);
    @(negedge clk);
    chk({tag, " done_pulse"}, done, 0);
    chk({tag, " idle"}, busy, 0);
  endtask

  initial begin
    int n;
    int dn;
    logic [W-1:0] oa [3];
    logic [W-1:0] ob [3];
    logic [W-1:0] od [3];
    logic         obr[3];
    logic         oov[3];

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst diff", diff, 0);
    chk("rst borrow", borrow, 0);
    chk("rst ovf", ovf, 0);

    // start on the very first edge after release
    rst_n = 1'b1;
    run_op("5-3", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op("3-5", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, OVF_ON);
    run_op("ff-ff", 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op("7f-80", 8'h7F, 8'h80, 8'hFF, 1'b1, OVF_ON);

    // start held high with new operands during RUN
    start = 1'b1; a = 8'h05; b = 8'h03; n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin a = 8'h10; b = 8'h01; end
    end while (!done && n < 40);
    chk("hold1 latency", n, W + 1);
    chk("hold1 diff", diff, 8'h02);
    chk("hold1 borrow", borrow, 0);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) begin chk("hold2 restart", busy, 1); start = 1'b0; end
    end while (!done && n < 40);
    chk("hold2 latency", n, W + 1);
    chk("hold2 diff", diff, 8'h0F);
    chk("hold2 borrow", borrow, 0);
    @(negedge clk);

    // back-to-back starts asserted in each DONE cycle
    oa = '{8'h05, 8'h80, 8'h00}; ob = '{8'h03, 8'h01, 8'hFF};
    od = '{8'h02, 8'h7F, 8'h01}; obr = '{1'b0, 1'b0, 1'b1}; oov = '{1'b0, OVF_ON, 1'b0};
    start = 1'b1; a = oa[0]; b = ob[0];
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!done && n < 40);
      chk($sformatf("b2b%0d period", i), n, W + 1);
      chk($sformatf("b2b%0d diff", i), diff, od[i]);
      chk($sformatf("b2b%0d borrow", i), borrow, obr[i]);
      chk($sformatf("b2b%0d ovf", i), ovf, oov[i]);
      if (i < 2) begin a = oa[i+1]; b = ob[i+1]; end
      else start = 1'b0;
    end
    @(negedge clk);

    // reset in RUN cycle 4 aborts the operation
    start = 1'b1; a = 8'h05; b = 8'h03;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort in_run", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort diff", diff, 0);
    chk("abort borrow", borrow, 0);
    chk("abort ovf", ovf, 0);
    @(negedge clk); rst_n = 1'b1;
    dn = 0;
    repeat (W + 4) begin @(negedge clk); dn += done; dn += busy; end
    chk("abort no_done", dn, 0);
    run_op("0-0", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
